uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single JTAG UART transmit byte stream between NUM_REQ core output streams. Round-robin arbitration with message-level locking: a granted requester keeps the UART until it sends TERM_BYTE or MAX_BURST bytes, so lines from different cores never interleave. Sits between the cores' output streams and the JTAG UART input stream in the top level. Has a one-entry output holding register.

Parameters:
NUM_REQ, 4, number of requester streams (2..16)
MAX_BURST, 64, max bytes per grant before forced release (>=1)
TERM_BYTE, 8'h0A, byte that ends a message and releases the lock
TIMEOUT, 16, stall cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_canGet  input  NUM_REQ  requester i has a byte available
in_getData  input  8*NUM_REQ  byte of requester i, bits [8i+7:8i]
in_get  output  NUM_REQ  consume pulse to requester i (one-hot or zero)
out_canGet  output  1  holding register valid (to UART in_canGet)
out_getData  output  8  holding register byte (to UART in_getData)
out_get  input  1  UART consumes the held byte this cycle
grant_valid  output  1  state is LOCKED
grant_idx  output  $clog2(NUM_REQ)  current/last granted requester

Behaviour:
- Stream rule: a byte moves when the consumer asserts get while canGet is high; data is valid with canGet. out_get while out_canGet is low is ignored.
- Reset (reset low, async): state IDLE, out_canGet 0, out_getData 0, in_get 0, grant_valid 0, grant_idx NUM_REQ-1 (so first search starts at 0), byte count 0, stall count 0. In-flight held byte is discarded.
- Holding register: may load when empty or drained in the same cycle: take = LOCKED && in_canGet[g] && (!out_canGet || out_get). in_get[g] = take (combinational); all other in_get bits 0. On take, out_getData <= in byte and out_canGet <= 1 next cycle; on out_get with no take, out_canGet <= 0. Input-to-output latency 1 cycle; sustained throughput 1 byte/cycle.
- IDLE: no in_get asserted. If any in_canGet set, grant requester found first searching grant_idx+1, +2, ... (mod NUM_REQ); next cycle LOCKED with grant_idx updated, count cleared. No request: stay IDLE, grant_idx unchanged.
- LOCKED: each take increments count (width $clog2(MAX_BURST+1)). Release (-> IDLE next cycle, grant_idx retained as round-robin pointer) on the take of a byte equal to TERM_BYTE, or on the take that makes count == MAX_BURST. Both true at once: single release.
- After release there is at least one IDLE cycle before the next grant; the just-released requester has lowest priority in that search.
- Held byte remains in holding register across release/regrant; no byte lost or duplicated.
- Requester dropping in_canGet mid-message: lock held (see optional feature).

Optional Feature:
ARB_TIMEOUT_EN: when defined, a stall counter in LOCKED counts consecutive cycles with in_canGet[g] low, cleared on any take and on entry to LOCKED; reaching TIMEOUT forces release to IDLE next cycle. When undefined, no counter exists and lock is held until TERM_BYTE or MAX_BURST (a silent core starves others).

Test Plan:
- Req 0 sends "hi\n", out_get always 1 -> UART receives 68 69 0A in order, one per cycle after 1-cycle grant + 1-cycle latency; grant_valid falls after 0A taken.
- Req 0 and 2 both hold "A\n"/"B\n" from reset -> output A 0A B 0A; grant_idx 0 then 2; never interleaved.
- Req 1 streams 70 bytes without 0A, MAX_BURST=64 -> release after byte 64; req 3 pending is granted next; req 1 resumes after.
- out_get held 0 for 5 cycles while req 0 has data -> exactly one byte held, in_get stays 0, no loss; resumes on out_get=1.
- reset pulled low mid-message with byte held -> out_canGet 0, grant_valid 0 immediately (async); after release arbitration restarts from req 0.
- With ARB_TIMEOUT_EN, TIMEOUT=16: req 0 sends "ab" then stalls, req 1 waiting -> release 16 cycles after last take, req 1 granted; without macro req 1 never granted.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked merge of core byte streams into the UART.
// Optional ARB_TIMEOUT_EN: force release of a lock whose owner stalls TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 64,
    parameter logic [7:0]  TERM_BYTE = 8'h0A,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         in_canGet,
    input  logic [8*NUM_REQ-1:0]       in_getData,
    output logic [NUM_REQ-1:0]         in_get,
    output logic                       out_canGet,
    output logic [7:0]                 out_getData,
    input  logic                       out_get,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 16 ||
        MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e        state_q;
    logic [IW-1:0] gidx_q;
    logic [CW-1:0] cnt_q;
    logic          ocv_q;
    logic [7:0]    odata_q;

    logic          take;
    logic [7:0]    in_byte;
    logic          last_byte;
    logic          burst_end;
    logic          found;
    logic [IW-1:0] next_idx;
    logic [IW-1:0] cand;

    assign in_byte   = in_getData[{gidx_q, 3'b000} +: 8];
    assign take      = (state_q == LOCKED) && in_canGet[gidx_q]
                       && (!ocv_q || out_get);
    assign last_byte = (in_byte == TERM_BYTE);
    assign burst_end = ((cnt_q + CW'(1)) == CW'(MAX_BURST));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_q;
    logic          stall_hit;

    assign stall_hit = (state_q == LOCKED) && !in_canGet[gidx_q]
                       && ((stall_q + SW'(1)) == SW'(TIMEOUT));

    // Count consecutive cycles the lock owner has nothing to send
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state_q != LOCKED || take || in_canGet[gidx_q]) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + SW'(1);
        end
    end
`endif

    // Search one past the last grant so the previous owner ranks last
    always_comb begin
        found    = 1'b0;
        next_idx = gidx_q;
        cand     = gidx_q;
        for (int o = 1; o <= int'(NUM_REQ); o++) begin
            cand = IW'((int'(gidx_q) + o) % int'(NUM_REQ));
            if (!found && in_canGet[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    // Consume pulse only to the lock owner, only when the byte moves
    always_comb begin
        in_get = '0;
        if (take) begin
            in_get[gidx_q] = 1'b1;
        end
    end

    // Arbitration FSM: grant, count the burst, release at message end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gidx_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= LOCKED;
                        gidx_q  <= next_idx;
                        cnt_q   <= '0;
                    end
                end
                LOCKED: begin
                    if (take) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (last_byte || burst_end) begin
                            state_q <= IDLE;
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (stall_hit) begin
                        state_q <= IDLE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One-entry holding register toward the UART, refilled while draining
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ocv_q   <= 1'b0;
            odata_q <= 8'h00;
        end else if (take) begin
            ocv_q   <= 1'b1;
            odata_q <= in_byte;
        end else if (out_get) begin
            ocv_q   <= 1'b0;
        end
    end

    assign out_canGet  = ocv_q;
    assign out_getData = odata_q;
    assign grant_valid = (state_q == LOCKED);
    assign grant_idx   = gidx_q;

endmodule
